// File: rtl/ft245_tx_8000.sv
// FT245 transmit path: buffers upstream bytes in a small FIFO and writes them to the
// FTDI through the asynchronous TXE#/WR# cycle, paced to 8000 bytes/s, with an unpaced banner.
module ft245_tx_8000 #(
  parameter int DIV        = 1500,
  parameter int FIFO_AW    = 4,
  parameter int WR_LOW_CYC = 2,
  parameter int GAP_CYC    = 3
) (
  input  logic               hwclk,
  input  logic               rst,
  inout  wire  [7:0]         in_out_245,
  input  logic               txe_245,
  output logic               wr_245,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               banner_req,
  output logic               tick_8k,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               late,
  output logic [2:0]         state_dbg
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(DIV);

  // Handshake: a byte transfers on any hwclk edge where s_valid && s_ready.
  // s_ready is registered from the occupancy, so a full FIFO never takes a push.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       phase_cnt, phase_nx;
  logic             txe_m, txe_s;
  logic [CW-1:0]    pace_cnt;
  logic             credit;
  logic             banner_pend;
  logic [2:0]       banner_idx;
  logic [7:0]       banner_byte;
  logic [7:0]       tx_data;
  logic             oe;
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count_nx;
  logic             push, pop;
  logic             send_banner, send_fifo;

  always_ff @(posedge hwclk) begin
    if (rst) begin
      txe_m <= 1'b1;
      txe_s <= 1'b1;
    end else begin
      txe_m <= txe_245;
      txe_s <= txe_m;
    end
  end

  assign tick_8k = (pace_cnt == CW'(DIV - 1));

  always_ff @(posedge hwclk) begin
    if (rst || tick_8k) pace_cnt <= '0;
    else                pace_cnt <= pace_cnt + 1'b1;
  end

  // Banner outranks the FIFO and ignores credit; FIFO bytes need one credit each.
  assign send_banner = (state == S_IDLE) && !txe_s && banner_pend;
  assign send_fifo   = (state == S_IDLE) && !txe_s && !banner_pend &&
                       (fifo_count != '0) && credit;

  assign push = s_valid && s_ready;
  assign pop  = send_fifo;

  always_comb begin
    count_nx = fifo_count;
    if (push && !pop)      count_nx = fifo_count + 1'b1;
    else if (!push && pop) count_nx = fifo_count - 1'b1;
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      s_ready    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_nx;
      s_ready    <= (count_nx != (FIFO_AW + 1)'(DEPTH));
    end
  end

  always_ff @(posedge hwclk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // A tick arriving while a pop consumes the old credit refills it rather than flagging late.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      credit <= 1'b0;
      late   <= 1'b0;
    end else begin
      if (tick_8k)       credit <= 1'b1;
      else if (send_fifo) credit <= 1'b0;
      if (tick_8k && credit && (fifo_count != '0) && !send_fifo) late <= 1'b1;
    end
  end

  always_comb begin
    banner_byte = 8'h55;
    case (banner_idx)
      3'd0:    banner_byte = 8'h55;
      3'd1:    banner_byte = 8'h54;
      3'd2:    banner_byte = 8'h4E;
      3'd3:    banner_byte = 8'h76;
      3'd4:    banner_byte = 8'h31;
      default: banner_byte = 8'h55;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      banner_pend <= 1'b0;
      banner_idx  <= '0;
    end else if (banner_req && !banner_pend) begin
      banner_pend <= 1'b1;
      banner_idx  <= '0;
    end else if (send_banner) begin
      banner_idx <= banner_idx + 1'b1;
      if (banner_idx == 3'd4) banner_pend <= 1'b0;
    end
  end

  always_ff @(posedge hwclk) begin
    if (rst)              tx_data <= '0;
    else if (send_banner) tx_data <= banner_byte;
    else if (send_fifo)   tx_data <= mem[rd_ptr];
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
    end else begin
      state     <= state_nx;
      phase_cnt <= phase_nx;
    end
  end

  // The IDLE decision cycle is the last cycle of the post-write gap, so GAP itself
  // runs GAP_CYC-1 cycles and a byte occupies the bus for 1+WR_LOW_CYC+1+GAP_CYC cycles.
  always_comb begin
    state_nx = state;
    phase_nx = phase_cnt;
    case (state)
      S_IDLE: begin
        if (send_banner || send_fifo) state_nx = S_SETUP;
      end
      S_SETUP: begin
        state_nx = S_STROBE;
        phase_nx = '0;
      end
      S_STROBE: begin
        if (phase_cnt == 8'(WR_LOW_CYC - 1)) state_nx = S_HOLD;
        else                                  phase_nx = phase_cnt + 1'b1;
      end
      S_HOLD: begin
        state_nx = S_GAP;
        phase_nx = '0;
      end
      S_GAP: begin
        if (phase_cnt == 8'(GAP_CYC - 2)) state_nx = S_IDLE;
        else                               phase_nx = phase_cnt + 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign oe         = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
  assign wr_245     = (state != S_STROBE);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;
  assign in_out_245 = oe ? tx_data : 8'bzzzz_zzzz;

endmodule
